// File: rtl/cmsdk_fpga_sram_arb.sv
// cmsdk_fpga_sram_arb
// Two-master round-robin arbiter in front of a single-port, pipelined-read,
// byte-write cmsdk_fpga_sram. M0 is the CPU side, M1 the DMA/debug side.
// Grant and SRAM drive are combinational in the request cycle; read data
// returns one cycle later, tagged with the master that issued the read.
//
// Optional feature: define SRAM_ARB_LOCK_EN to enable lock mode, in which a
// master may own the SRAM for an atomic sequence bounded by LOCK_MAX cycles.
// Without the macro, Mx_LOCK and LOCK_MAX are ignored.
module cmsdk_fpga_sram_arb #(
   parameter int AW       = 16,
   parameter int LOCK_MAX = 16
) (
   input  logic          CLK,
   input  logic          RST,

   input  logic          M0_REQ,
   input  logic          M0_LOCK,
   input  logic [AW-1:0] M0_ADDR,
   input  logic [31:0]   M0_WDATA,
   input  logic [3:0]    M0_WREN,
   output logic          M0_GNT,
   output logic          M0_RVALID,
   output logic [31:0]   M0_RDATA,

   input  logic          M1_REQ,
   input  logic          M1_LOCK,
   input  logic [AW-1:0] M1_ADDR,
   input  logic [31:0]   M1_WDATA,
   input  logic [3:0]    M1_WREN,
   output logic          M1_GNT,
   output logic          M1_RVALID,
   output logic [31:0]   M1_RDATA,

   output logic [AW-1:0] SRAM_ADDR,
   output logic [31:0]   SRAM_WDATA,
   output logic [3:0]    SRAM_WREN,
   output logic          SRAM_CS,
   input  logic [31:0]   SRAM_RDATA
);

   // Grant decisions for the current cycle
   logic gnt0;
   logic gnt1;

   // Round-robin choice when not locked: the master that did not win last
   logic idle_gnt0;
   logic idle_gnt1;

   // last_q = ID of the most recently granted master
   logic last_q;
   logic last_d;

   // Read tag: a read was granted last cycle, and by whom
   logic rd_v_q;
   logic rd_v_d;
   logic rd_id_q;
   logic rd_id_d;

`ifdef SRAM_ARB_LOCK_EN
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_LOCK0 = 2'd1;
   localparam logic [1:0] ST_LOCK1 = 2'd2;

   // Counter value at which the owner's lock is forcibly released
   localparam logic [7:0] CNT_LAST = 8'(LOCK_MAX - 1);

   logic [1:0] state_q;
   logic [1:0] state_d;
   logic [7:0] cnt_q;
   logic [7:0] cnt_d;
`else
   // Lock inputs and timeout have no function in this build
   logic unused_lock;
   assign unused_lock = M0_LOCK ^ M1_LOCK;
   localparam int UNUSED_LOCK_MAX = LOCK_MAX;
`endif

   assign idle_gnt0 = M0_REQ & (~M1_REQ | last_q);
   assign idle_gnt1 = M1_REQ & (~M0_REQ | ~last_q);

   // Pick at most one master this cycle; nothing is granted during reset
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (!RST) begin
`ifdef SRAM_ARB_LOCK_EN
         if (state_q == ST_LOCK0) begin
            gnt0 = M0_REQ;
         end else if (state_q == ST_LOCK1) begin
            gnt1 = M1_REQ;
         end else begin
            gnt0 = idle_gnt0;
            gnt1 = idle_gnt1;
         end
`else
         gnt0 = idle_gnt0;
         gnt1 = idle_gnt1;
`endif
      end
   end

   // Steer the granted master onto the SRAM port; M0 fields idle on the bus
   always_comb begin
      SRAM_CS    = gnt0 | gnt1;
      SRAM_ADDR  = gnt1 ? M1_ADDR  : M0_ADDR;
      SRAM_WDATA = gnt1 ? M1_WDATA : M0_WDATA;
      SRAM_WREN  = 4'b0000;
      if (gnt0) begin
         SRAM_WREN = M0_WREN;
      end else if (gnt1) begin
         SRAM_WREN = M1_WREN;
      end
   end

   // Next arbitration pointer, read tag and (optionally) lock state
   always_comb begin
      last_d  = last_q;
      rd_v_d  = (gnt0 && (M0_WREN == 4'b0000)) || (gnt1 && (M1_WREN == 4'b0000));
      rd_id_d = gnt1;
      if (gnt0) begin
         last_d = 1'b0;
      end else if (gnt1) begin
         last_d = 1'b1;
      end
`ifdef SRAM_ARB_LOCK_EN
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            cnt_d = 8'd0;
            if (gnt0 && M0_LOCK) begin
               state_d = ST_LOCK0;
            end else if (gnt1 && M1_LOCK) begin
               state_d = ST_LOCK1;
            end
         end
         ST_LOCK0: begin
            cnt_d = cnt_q + 8'd1;
            if (cnt_q == CNT_LAST) begin
               // Timeout: the other master wins the next contention
               state_d = ST_IDLE;
               cnt_d   = 8'd0;
               last_d  = 1'b0;
            end else if (gnt0 && !M0_LOCK) begin
               state_d = ST_IDLE;
               cnt_d   = 8'd0;
            end
         end
         ST_LOCK1: begin
            cnt_d = cnt_q + 8'd1;
            if (cnt_q == CNT_LAST) begin
               state_d = ST_IDLE;
               cnt_d   = 8'd0;
               last_d  = 1'b1;
            end else if (gnt1 && !M1_LOCK) begin
               state_d = ST_IDLE;
               cnt_d   = 8'd0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = 8'd0;
         end
      endcase
`endif
   end

   // Register control state; reset drops any lock and any pending read return
   always_ff @(posedge CLK) begin
      if (RST) begin
         last_q  <= 1'b1;
         rd_v_q  <= 1'b0;
         rd_id_q <= 1'b0;
`ifdef SRAM_ARB_LOCK_EN
         state_q <= ST_IDLE;
         cnt_q   <= 8'd0;
`endif
      end else begin
         last_q  <= last_d;
         rd_v_q  <= rd_v_d;
         rd_id_q <= rd_id_d;
`ifdef SRAM_ARB_LOCK_EN
         state_q <= state_d;
         cnt_q   <= cnt_d;
`endif
      end
   end

   assign M0_GNT    = gnt0;
   assign M1_GNT    = gnt1;
   assign M0_RVALID = rd_v_q & ~rd_id_q;
   assign M1_RVALID = rd_v_q &  rd_id_q;
   assign M0_RDATA  = SRAM_RDATA;
   assign M1_RDATA  = SRAM_RDATA;

endmodule

// File: doc/cmsdk_fpga_sram_arb.md
# cmsdk_fpga_sram_arb

Two-master arbiter that shares one cmsdk_fpga_sram instance (single-port, pipelined read, byte-write) between a CPU-side port (M0) and a DMA/debug port (M1). It grants at most one access per cycle with round-robin fairness, drives the SRAM port from the granted master, and returns read data to that master one cycle later. An optional lock mode lets a master own the SRAM for an atomic sequence, bounded by a cycle timeout.

## Interface
- AW, 16, SRAM word-address width; must match the attached SRAM.
- LOCK_MAX, 16, maximum cycles a master may hold a lock (2..255).

- CLK  in  1  clock.
- RST  in  1  reset; synchronous, active-high.
- M0_REQ / M1_REQ  in  1  access request.
- M0_LOCK / M1_LOCK  in  1  hold ownership after this access (lock feature only).
- M0_ADDR / M1_ADDR  in  AW  word address.
- M0_WDATA / M1_WDATA  in  32  write data.
- M0_WREN / M1_WREN  in  4  byte write enables; 4'b0000 = read.
- M0_GNT / M1_GNT  out  1  access accepted this cycle (combinational).
- M0_RVALID / M1_RVALID  out  1  read data valid (registered).
- M0_RDATA / M1_RDATA  out  32  read data; both equal SRAM_RDATA.
- SRAM_ADDR  out  AW  to SRAM ADDR.
- SRAM_WDATA  out  32  to SRAM WDATA.
- SRAM_WREN  out  4  to SRAM WREN.
- SRAM_CS  out  1  to SRAM CS.
- SRAM_RDATA  in  32  from SRAM RDATA.

## Operation
- State: FSM {IDLE, LOCK0, LOCK1}; last-grant pointer `last` (1 bit); 8-bit lock cycle counter; read tag {rd_v, rd_id}.
- IDLE:
  - One requester: it is granted.
  - Both requesting: the master != `last` is granted.
  - `last` updates to the granted ID on every grant.
- LOCKn: only Mn can be granted. The other master is blocked even while Mn is idle.
- Transitions (lock feature only):
  - IDLE -> LOCKn when Mn is granted with Mn_LOCK=1.
  - LOCKn -> IDLE when Mn is granted with Mn_LOCK=0 (final beat).
  - LOCKn -> IDLE on timeout: counter reaches LOCK_MAX-1. Mn's grant in that cycle, if any, is still honoured. `last` is forced to n so the other master wins the next contention.
- Lock counter: clears on entry to LOCKn and increments each cycle in LOCKn.
- SRAM drive:
  - SRAM_CS = any grant.
  - SRAM_ADDR, SRAM_WDATA, SRAM_WREN = the granted master's signals.
  - When no grant: SRAM_WREN=0, SRAM_CS=0; SRAM_ADDR and SRAM_WDATA hold the M0 values (don't-care).
- Read tag: on a granted read (WREN==0), next cycle rd_v=1 and rd_id=granted ID; otherwise rd_v=0.
- Read return: Mx_RVALID = rd_v & (rd_id==x).
- Writes produce no RVALID.

## Timing
- Grant and SRAM drive are combinational from REQ, LOCK, FSM and `last`, in the request cycle. A master holds REQ and its fields until it sees GNT.
- Read latency: request in cycle T, GNT in T, RVALID and RDATA in T+1. Back-to-back reads from alternating masters give one RVALID per cycle, each to the correct master.
- Write: committed at the CLK edge ending cycle T.
- While RST=1:
  - GNT=0, SRAM_CS=0, SRAM_WREN=0.
  - Next-cycle RVALID=0.
  - FSM -> IDLE, `last` -> 1 (M0 wins first contention), counter -> 0.
- Reset mid-operation:
  - A read granted in the cycle RST rises gets no RVALID.
  - An active lock is dropped.
- Simultaneous final lock beat plus the other master requesting: the lock owner is granted this cycle, and the other master gets the next cycle.

## Configuration
- SRAM_ARB_LOCK_EN defined: lock behaviour and timeout as above.
- SRAM_ARB_LOCK_EN undefined:
  - Mx_LOCK ignored.
  - FSM and counter removed; arbiter is pure round-robin from IDLE.
  - LOCK_MAX unused.

## Test plan
- Single read: RST released, M0 reads addr 0x0010 (preloaded 0xDEADBEEF) -> M0_GNT same cycle, M0_RVALID=1 with M0_RDATA=0xDEADBEEF next cycle, M1_RVALID=0.
- Contention: both masters request reads continuously for 6 cycles -> grants M0,M1,M0,M1,M0,M1, with RVALID routed to the matching master each following cycle.
- Byte write: M1 writes 0x11223344 with WREN=4'b0101 to 0x0020 (was 0xAABBCCDD), then reads it -> 0xAA22CC44.
- Lock (LOCK_EN): M1 locks for 3 beats while M0 requests continuously -> M0_GNT=0 until M1's LOCK=0 beat, then M0 is granted the next cycle.
- Timeout (LOCK_EN, LOCK_MAX=4): M0 holds LOCK=1 forever, M1 requesting -> M1 granted exactly 4 cycles after lock entry.
- Reset mid-read: assert RST in the cycle M0's read is granted -> no RVALID afterward, and first post-reset contention grants M0.
